dcim_seq: RTL and testbench
===========================

DCIM_SEQ -- requirements
Module: dcim_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waited for st.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  in  1  operation request.
REQ-005 SHALL have port cmd_ready  out  1  high only in IDLE.
REQ-006 SHALL have port cmd_cfg  in  4  {load, cima, inwidth, wwidth}.
REQ-007 SHALL have port cmd_x  in  192  activation vector for the operation.
REQ-008 SHALL have port w_valid  in  1  weight beat valid.
REQ-009 SHALL have port w_ready  out  1  high only in LOAD.
REQ-010 SHALL have port w_data  in  24  weight row data.
REQ-011 SHALL have port res_valid  out  1  result held for consumer.
REQ-012 SHALL have port res_ready  in  1  consumer accepts result.
REQ-013 SHALL have port res_data  out  51  captured nout.
REQ-014 SHALL have port res_err  out  1  result is a timeout, res_data zero.
REQ-015 SHALL have port D  out  24  macro write data.
REQ-016 SHALL have port WA  out  8  macro one-hot row write address.
REQ-017 SHALL have port acm_en  out  1  macro access enable.
REQ-018 SHALL have ports cima, inwidth, wwidth  out  1 each  macro mode, held from cmd_cfg.
REQ-019 SHALL have port start  out  1  macro compute start pulse.
REQ-020 SHALL have port xin0  out  192  macro activation input.
REQ-021 SHALL have port nout  in  51  macro result.
REQ-022 SHALL have port st  in  1  macro done level.

Function
REQ-023 SHALL implement states IDLE, LOAD, SETUP, START, WAIT, RESULT; all outputs registered.
REQ-024 IDLE: on cmd_valid&&cmd_ready, register cmd_cfg and cmd_x (to xin0); next state LOAD if load=1 else SETUP.
REQ-025 LOAD: each w_valid&&w_ready beat k (0..7) SHALL drive next cycle WA=1<<k, D=w_data, acm_en=1; no beat -> WA=0, D=0.
REQ-026 After beat 7, SHALL emit one cycle WA=0, D=0 then enter SETUP; row counter 3 bits, clears on leaving LOAD.
REQ-027 SETUP: one cycle with xin0 stable and start=0; then START.
REQ-028 START: start=1 for exactly one cycle; then WAIT with timeout counter cleared.
REQ-029 WAIT: first cycle st==1 SHALL latch nout into res_data, res_err=0, go RESULT; st already high on WAIT entry counts.
REQ-030 WAIT: counter reaching TIMEOUT without st SHALL set res_err=1, res_data=0, go RESULT.
REQ-031 RESULT: res_valid=1, res_data/res_err stable until res_ready; same-cycle accept -> IDLE next cycle, cmd_ready=1 the cycle after.
REQ-032 xin0, cima, inwidth, wwidth SHALL hold from capture until next command; acm_en=1 from IDLE exit through WAIT.
REQ-033 cmd_valid outside IDLE and w_valid outside LOAD SHALL be ignored.

Reset
REQ-034 rstn low SHALL force IDLE and zero all outputs, counters, registers, asynchronously, including mid-LOAD/WAIT (operation aborted, no result).
REQ-035 After rstn release, cmd_ready SHALL rise on the first clock edge.

Structure
REQ-036 Package dcim_pkg SHALL hold the state enum, NUM_ROWS=8, D_W=24, X_W=192, NOUT_W=51.
REQ-037 Single module, no sub-module; timeout counter width $clog2(TIMEOUT+1).

Verification
REQ-038 load=1, weights 1..8, cmd_x all-ones -> WA 01,02,..,80 with D 1..8, one WA=0 cycle, start pulse width 1.
REQ-039 load=0 -> no WA activity; start asserted 2 cycles after command handshake.
REQ-040 st rises 20 cycles after start, nout=51'h123 -> res_valid, res_data=51'h123, res_err=0 until res_ready.
REQ-041 st never rises, TIMEOUT=16 -> res_err=1, res_data=0 after 16 WAIT cycles.
REQ-042 rstn low during LOAD beat 4 -> all outputs 0 immediately, IDLE, no result; next command completes normally.

Source files
------------

// File: rtl/dcim_pkg.sv
// Shared types and geometry for the DCIM macro sequencer.
package dcim_pkg;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned D_W      = 24;
  localparam int unsigned X_W      = 192;
  localparam int unsigned NOUT_W   = 51;
  localparam int unsigned ROW_W    = $clog2(NUM_ROWS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StStart,
    StWait,
    StResult
  } state_e;

endpackage

// File: rtl/dcim_seq.sv
// Sequencer for a digital compute-in-memory macro: optional weight load, compute start,
// bounded wait for done, and a held result handed to a ready/valid consumer.
module dcim_seq
  import dcim_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_cfg,
  input  logic [X_W-1:0]    cmd_x,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [D_W-1:0]    w_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NOUT_W-1:0] res_data,
  output logic              res_err,
  output logic [D_W-1:0]    D,
  output logic [NUM_ROWS-1:0] WA,
  output logic              acm_en,
  output logic              cima,
  output logic              inwidth,
  output logic              wwidth,
  output logic              start,
  output logic [X_W-1:0]    xin0,
  input  logic [NOUT_W-1:0] nout,
  input  logic              st
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(NUM_ROWS - 1);

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                drain_q, drain_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [X_W-1:0]      xin_q, xin_d;
  logic                cima_q, cima_d;
  logic                inwidth_q, inwidth_d;
  logic                wwidth_q, wwidth_d;
  logic [NUM_ROWS-1:0] wa_q, wa_d;
  logic [D_W-1:0]      dat_q, dat_d;
  logic [NOUT_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                w_ready_q, w_ready_d;
  logic                acm_en_q, acm_en_d;
  logic                start_q, start_d;
  logic                res_valid_q, res_valid_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    drain_d    = drain_q;
    cnt_d      = cnt_q;
    xin_d      = xin_q;
    cima_d     = cima_q;
    inwidth_d  = inwidth_q;
    wwidth_d   = wwidth_q;
    wa_d       = '0;
    dat_d      = '0;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          xin_d     = cmd_x;
          cima_d    = cmd_cfg[2];
          inwidth_d = cmd_cfg[1];
          wwidth_d  = cmd_cfg[0];
          state_d   = cmd_cfg[3] ? StLoad : StSetup;
        end
      end
      StLoad: begin
        // After the last row one idle write cycle (WA=0) precedes compute setup.
        if (drain_q) begin
          drain_d = 1'b0;
          row_d   = '0;
          state_d = StSetup;
        end else if (w_valid && w_ready_q) begin
          wa_d  = NUM_ROWS'(1) << row_q;
          dat_d = w_data;
          row_d = row_q + ROW_W'(1);
          if (row_q == RowLast) drain_d = 1'b1;
        end
      end
      StSetup: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (st) begin
          res_data_d = nout;
          res_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = StResult;
        end else if (cnt_q == TmoLast) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = StResult;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they align with it.
    cmd_ready_d = (state_d == StIdle);
    w_ready_d   = (state_d == StLoad) && !drain_d;
    acm_en_d    = (state_d == StLoad) || (state_d == StSetup) ||
                  (state_d == StStart) || (state_d == StWait);
    start_d     = (state_d == StStart);
    res_valid_d = (state_d == StResult);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      row_q       <= '0;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      xin_q       <= '0;
      cima_q      <= 1'b0;
      inwidth_q   <= 1'b0;
      wwidth_q    <= 1'b0;
      wa_q        <= '0;
      dat_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      w_ready_q   <= 1'b0;
      acm_en_q    <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      xin_q       <= xin_d;
      cima_q      <= cima_d;
      inwidth_q   <= inwidth_d;
      wwidth_q    <= wwidth_d;
      wa_q        <= wa_d;
      dat_q       <= dat_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      cmd_ready_q <= cmd_ready_d;
      w_ready_q   <= w_ready_d;
      acm_en_q    <= acm_en_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign w_ready   = w_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign D         = dat_q;
  assign WA        = wa_q;
  assign acm_en    = acm_en_q;
  assign cima      = cima_q;
  assign inwidth   = inwidth_q;
  assign wwidth    = wwidth_q;
  assign start     = start_q;
  assign xin0      = xin_q;

endmodule

// File: tb/tb_dcim_seq.sv
// Directed bench for dcim_seq: a default-timeout instance for the main flows and a
// TIMEOUT=16 instance for the timeout path.
module tb_dcim_seq;
  import dcim_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [3:0]        cmd_cfg = '0;
  logic [X_W-1:0]    cmd_x = '0;
  logic              w_valid = 1'b0;
  logic [D_W-1:0]    w_data = '0;
  logic              res_ready = 1'b0, res_ready2 = 1'b0;
  logic [NOUT_W-1:0] nout = '0;
  logic              st = 1'b0;

  logic cmd_ready, w_ready, res_valid, res_err, acm_en, cima, inwidth, wwidth, start;
  logic [NOUT_W-1:0] res_data;
  logic [D_W-1:0]    D;
  logic [7:0]        WA;
  logic [X_W-1:0]    xin0;

  logic cmd_ready2, w_ready2, res_valid2, res_err2, acm_en2, cima2, inwidth2, wwidth2, start2;
  logic [NOUT_W-1:0] res_data2;
  logic [D_W-1:0]    D2;
  logic [7:0]        WA2;
  logic [X_W-1:0]    xin02;

  logic [283:0] all_out;
  assign all_out = {cmd_ready, w_ready, res_valid, res_err, acm_en, cima, inwidth, wwidth,
                    start, WA, D, xin0, res_data};

  int checks = 0;
  int errors = 0;

  localparam logic [X_W-1:0] Pat = {6{32'hDEADBEEF}};

  dcim_seq u_dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg),
    .cmd_x(cmd_x), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .D(D), .WA(WA), .acm_en(acm_en), .cima(cima), .inwidth(inwidth), .wwidth(wwidth),
    .start(start), .xin0(xin0), .nout(nout), .st(st)
  );

  dcim_seq #(.TIMEOUT(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_cfg(cmd_cfg),
    .cmd_x(cmd_x), .w_valid(w_valid), .w_ready(w_ready2), .w_data(w_data),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2), .res_err(res_err2),
    .D(D2), .WA(WA2), .acm_en(acm_en2), .cima(cima2), .inwidth(inwidth2), .wwidth(wwidth2),
    .start(start2), .xin0(xin02), .nout(nout), .st(st)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b exp 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready2 !== 1'b1) begin
      errors++; $display("FAIL ready_first_edge got %b%b exp 11", cmd_ready, cmd_ready2);
    end
  endtask

  task automatic test_load();
    cmd_valid = 1'b1; cmd_cfg = 4'b1101; cmd_x = {X_W{1'b1}};
    tick();
    cmd_valid = 1'b0; cmd_x = '0;
    checks++;
    if ({cmd_ready, w_ready, acm_en, cima, inwidth, wwidth, WA} !== {6'b011101, 8'h00} ||
        xin0 !== {X_W{1'b1}}) begin
      errors++;
      $display("FAIL load_entry got rdy%b wr%b en%b cfg%b%b%b wa%h exp rdy0 wr1 en1 cfg101 wa00",
               cmd_ready, w_ready, acm_en, cima, inwidth, wwidth, WA);
    end
    for (int k = 0; k < 8; k++) begin
      w_valid = 1'b1; w_data = 24'(k + 1);
      tick();
      checks++;
      if (WA !== 8'(1 << k) || D !== 24'(k + 1)) begin
        errors++; $display("FAIL load_beat%0d got WA=%h D=%h exp WA=%h D=%h", k, WA, D,
                           8'(1 << k), 24'(k + 1));
      end
      if (k == 3) begin
        w_valid = 1'b0;
        tick();
        checks++;
        if (WA !== 8'h00 || D !== 24'h0) begin
          errors++; $display("FAIL load_gap got WA=%h D=%h exp 00/0", WA, D);
        end
      end
    end
    w_valid = 1'b0;
    checks++;
    if (w_ready !== 1'b0) begin
      errors++; $display("FAIL w_ready_drop got %b exp 0", w_ready);
    end
    w_valid = 1'b1; w_data = 24'hABCDEF;
    tick();
    checks++;
    if (WA !== 8'h00 || D !== 24'h0 || start !== 1'b0) begin
      errors++; $display("FAIL post_load_idle got WA=%h D=%h start=%b exp 00/0/0", WA, D, start);
    end
    tick();
    checks++;
    if (start !== 1'b1 || WA !== 8'h00) begin
      errors++; $display("FAIL load_start got start=%b WA=%h exp 1/00", start, WA);
    end
    w_valid = 1'b0;
    tick();
    checks++;
    if (start !== 1'b0 || acm_en !== 1'b1) begin
      errors++; $display("FAIL start_width got start=%b acm_en=%b exp 0/1", start, acm_en);
    end
    st = 1'b1; nout = 51'h5A5A;
    tick();
    st = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 51'h5A5A || res_err !== 1'b0 || acm_en !== 1'b0) begin
      errors++; $display("FAIL load_result got v=%b d=%h e=%b en=%b exp 1/5a5a/0/0",
                         res_valid, res_data, res_err, acm_en);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_accept got v=%b rdy=%b exp 0/1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_noload();
    cmd_valid = 1'b1; cmd_cfg = 4'b0010; cmd_x = Pat;
    tick();
    cmd_x = ~Pat;
    checks++;
    if (start !== 1'b0 || WA !== 8'h00 || acm_en !== 1'b1 || w_ready !== 1'b0 ||
        {cima, inwidth, wwidth} !== 3'b010) begin
      errors++; $display("FAIL noload_setup got start=%b WA=%h en=%b wr=%b cfg=%b%b%b",
                         start, WA, acm_en, w_ready, cima, inwidth, wwidth);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (start !== 1'b1 || WA !== 8'h00) begin
      errors++; $display("FAIL start_2_after_hs got start=%b WA=%h exp 1/00", start, WA);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0 || start !== 1'b0 || WA !== 8'h00) begin
        errors++; $display("FAIL wait_quiet%0d got v=%b start=%b WA=%h exp 0/0/00",
                           i, res_valid, start, WA);
      end
    end
    st = 1'b1; nout = 51'h123;
    tick();
    st = 1'b0; nout = 51'h7FFFF;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 51'h123 || res_err !== 1'b0 || xin0 !== Pat) begin
      errors++; $display("FAIL st_result got v=%b d=%h e=%b xin0=%h exp 1/123/0/%h",
                         res_valid, res_data, res_err, xin0, Pat);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 51'h123 || res_err !== 1'b0) begin
        errors++; $display("FAIL result_hold%0d got v=%b d=%h e=%b exp 1/123/0",
                           i, res_valid, res_data, res_err);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL noload_accept got v=%b rdy=%b exp 0/1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    cmd_valid2 = 1'b1; cmd_cfg = 4'b0000;
    tick();
    cmd_valid2 = 1'b0;
    tick();
    checks++;
    if (start2 !== 1'b1) begin
      errors++; $display("FAIL tmo_start got %b exp 1", start2);
    end
    nout = 51'h7_ABCD_1234_5678;
    tick();
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (res_valid2 !== 1'b0) begin
        errors++; $display("FAIL tmo_early%0d got v=%b exp 0", i, res_valid2);
      end
      tick();
    end
    checks++;
    if (res_valid2 !== 1'b1 || res_err2 !== 1'b1 || res_data2 !== '0) begin
      errors++; $display("FAIL tmo_result got v=%b e=%b d=%h exp 1/1/0",
                         res_valid2, res_err2, res_data2);
    end
    res_ready2 = 1'b1;
    tick();
    res_ready2 = 1'b0;
    checks++;
    if (res_valid2 !== 1'b0 || cmd_ready2 !== 1'b1) begin
      errors++; $display("FAIL tmo_accept got v=%b rdy=%b exp 0/1", res_valid2, cmd_ready2);
    end
  endtask

  task automatic test_reset_mid_load();
    cmd_valid = 1'b1; cmd_cfg = 4'b1000; cmd_x = Pat;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w_valid = 1'b1; w_data = 24'(k + 1);
      tick();
    end
    checks++;
    if (WA !== 8'h10 || D !== 24'h5) begin
      errors++; $display("FAIL beat4 got WA=%h D=%h exp 10/5", WA, D);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_mid_load got %h exp 0", all_out);
    end
    @(negedge clk);
    rstn = 1'b1; w_valid = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || WA !== 8'h00 || acm_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b v=%b WA=%h en=%b exp 1/0/00/0",
                         cmd_ready, res_valid, WA, acm_en);
    end
    cmd_valid = 1'b1; cmd_cfg = 4'b0000; cmd_x = ~Pat;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (start !== 1'b1) begin
      errors++; $display("FAIL post_reset_start got %b exp 1", start);
    end
    st = 1'b1; nout = 51'h42;
    tick();
    tick();
    st = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 51'h42 || res_err !== 1'b0 || xin0 !== ~Pat) begin
      errors++; $display("FAIL post_reset_result got v=%b d=%h e=%b exp 1/42/0",
                         res_valid, res_data, res_err);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_accept got v=%b rdy=%b exp 0/1", res_valid, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_noload();
    test_timeout();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
